seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Display-side consumer of the counter FSM's indication bus. It takes the 8-bit indication value (`dind`) and the 2-bit state code (`debug`) and converts the value from binary to BCD with a sequential double-dabble engine. It then time-multiplexes four active-low seven-segment digits onto the board display. It sits between `counter_fsm` and the board pins, in the same clock domain.

## Interface
Parameters:
- `SCAN_DIV`, default 4: clocks each digit stays lit. Legal range is 2..65535.

Ports:
- `clc_i`, in, 1: system clock; the only clock.
- `rst_i`, in, 1: reset. **Synchronous, active-high.**
- `dind_i`, in, 8: indication value, unsigned 0..255.
- `debug_i`, in, 2: state code, 0..3.
- `seg_out`, out, 8: segments, active-low. Bit order is {dp,g,f,e,d,c,b,a}.
- `an_out`, out, 4: digit enables, active-low and one-hot. Bit0 is the rightmost digit.
- `busy_out`, out, 1: high while a conversion is in progress.

## Operation
- Digit mapping:
  - Digit 0: ones.
  - Digit 1: tens.
  - Digit 2: hundreds.
  - Digit 3: `debug_i` shown as a decimal digit 0..3.
- Digit registers are 5 bits wide. Bit4 set means the digit is blank (`seg_out` = 8'hFF). The decimal point is always off.
- Leading-zero blanking:
  - Hundreds is blank when the value is below 100.
  - Tens is blank when the value is below 10.
  - Ones is never blank.
- Conversion FSM has three states: IDLE, SHIFT, LOAD.
  - IDLE: compare {`debug_i`,`dind_i`} with the stored shown-snapshot. On a mismatch, or if the `first` flag is set, capture the input and go to SHIFT.
  - SHIFT: runs exactly 8 cycles. Each cycle adds 3 to every BCD nibble that is ≥5, then shifts the 20-bit {bcd,bin} register left by 1. The bit counter runs 7→0.
  - LOAD: write the three digit registers (with blanking applied) and the state digit. Update the snapshot, clear `first`, return to IDLE.
- Input changes during SHIFT/LOAD are ignored. They are picked up on the next IDLE compare.
- Scan logic:
  - The prescaler counts 0..`SCAN_DIV`-1.
  - On wrap, the digit index increments 0→1→2→3→0.
  - Every non-reset cycle: `an_out` <= ~(1<<idx) and `seg_out` <= decode(digit[idx]).
- Decode table (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- Reset values:
  - `seg_out`=8'hFF, `an_out`=4'hF, `busy_out`=0.
  - FSM=IDLE, prescaler=0, idx=0, `first`=1.
  - Digits: ones=0, tens and hundreds blank, state=0.
- First cycle after reset release: `an_out`=4'hE, `seg_out`=8'hC0.
- Conversion latency, with capture in IDLE at cycle N:
  - SHIFT occupies N+1..N+8.
  - LOAD at N+9; digit registers are valid from N+10.
  - `seg_out` reflects the new digit at the first cycle ≥N+11 in which that digit is active.
- `busy_out` is high from N+1 through N+9 inclusive.
- Reset asserted mid-conversion aborts it. All state returns to reset values on the next edge, and `first` forces a fresh conversion after release.
- The prescaler and scan never stall during conversion. A digit update may land mid-slot; no glitch-free requirement applies beyond the register boundary.

## Configuration
- `SEG7_HEX_EN` defined (hex mode):
  - The BCD engine is not built.
  - IDLE goes directly to LOAD.
  - Digit 0 = `dind_i[3:0]`, digit 1 = `dind_i[7:4]`; neither is blanked.
  - Digit 2 is always blank. Digit 3 is the state code.
  - Digit registers are valid at N+2, and `busy_out` is high only in LOAD.
- `SEG7_HEX_EN` undefined: decimal mode as described above.

## Structure
- Package `seg7_pkg`:
  - FSM state localparams (IDLE/SHIFT/LOAD).
  - `DIGIT_BLANK` = 5'h10.
  - Segment constants `SEG_OFF` = 8'hFF and `AN_OFF` = 4'hF.
- One sub-module, `seg7_decode`: combinational 5-bit digit → 8-bit active-low segment pattern, blank-aware. It is instantiated once, after the index mux.

## Test plan
- Reset release with `SCAN_DIV`=4 and `dind_i`=0 → `an_out` steps E,D,B,7 every 4 clocks. The digit-0 slot shows C0 and the other digits show FF, until the first conversion completes.
- `dind_i`=123, `debug_i`=1 → after 10 clocks, the slots read B0 (digit 0), A4 (digit 1), F9 (digit 2), F9 (digit 3). `busy_out` is high for exactly 9 cycles.
- `dind_i`=7 → digits 2 and 1 show FF, digit 0 shows F8. `dind_i`=255 → A4, 92, 92.
- Change `dind_i` from 10 to 200 at SHIFT cycle 3 → digits first show 10 (F9,C0), then 200 after a second 9-cycle busy window.
- Assert `rst_i` for 1 clock mid-SHIFT → next edge gives `busy_out`=0, `an_out`=F, `seg_out`=FF, after which a conversion restarts automatically.
- With `SEG7_HEX_EN` defined and `dind_i`=8'hA5 → digit 0 shows 92 and digit 1 shows 88, with `busy_out` high for a single cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment scan driver:
//   conv_state_e  - conversion FSM states (IDLE, SHIFT, LOAD)
//   DIGIT_BLANK   - 5-bit digit code that lights no segments
//   SEG_OFF       - active-low segment pattern with every segment dark
//   AN_OFF        - active-low anode pattern with every digit disabled
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_e;

    localparam logic [4:0] DIGIT_BLANK = 5'h10;
    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam logic [3:0] AN_OFF      = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational digit-to-segment decoder, active-low, bit order {dp,g,f,e,d,c,b,a}.
// Ports:
//   digit_i [4:0] - bit4 set means blank, bits 3:0 are a hex digit
//   seg_o   [7:0] - segment pattern; the decimal point is always dark
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [4:0] digit_i,
    output logic [7:0] seg_o
);

    // Blank digits stay dark; otherwise a plain 16-entry hex glyph table.
    always_comb begin
        seg_o = SEG_OFF;
        if (!digit_i[4]) begin
            case (digit_i[3:0])
                4'h0: seg_o = 8'hC0;
                4'h1: seg_o = 8'hF9;
                4'h2: seg_o = 8'hA4;
                4'h3: seg_o = 8'hB0;
                4'h4: seg_o = 8'h99;
                4'h5: seg_o = 8'h92;
                4'h6: seg_o = 8'h82;
                4'h7: seg_o = 8'hF8;
                4'h8: seg_o = 8'h80;
                4'h9: seg_o = 8'h90;
                4'hA: seg_o = 8'h88;
                4'hB: seg_o = 8'h83;
                4'hC: seg_o = 8'hC6;
                4'hD: seg_o = 8'hA1;
                4'hE: seg_o = 8'h86;
                4'hF: seg_o = 8'h8E;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Converts the counter FSM's 8-bit indication value to decimal digits with a
// sequential double-dabble engine and scans four active-low digits.
// Digit 0..2 are ones/tens/hundreds (leading zeros blanked), digit 3 is the
// 2-bit state code.
// Build option: define SEG7_HEX_EN to show the value as two hex digits instead;
// the BCD engine is then not built and IDLE goes straight to LOAD.
// Parameters:
//   SCAN_DIV - clocks each digit stays lit (2..65535)
// Ports:
//   clc_i    - system clock
//   rst_i    - synchronous active-high reset
//   dind_i   - indication value 0..255
//   debug_i  - state code 0..3
//   seg_out  - segments, active-low {dp,g,f,e,d,c,b,a}
//   an_out   - digit enables, active-low one-hot, bit0 = rightmost digit
//   busy_out - high while a conversion is in progress
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clc_i,
    input  logic       rst_i,
    input  logic [7:0] dind_i,
    input  logic [1:0] debug_i,
    output logic [7:0] seg_out,
    output logic [3:0] an_out,
    output logic       busy_out
);

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

    conv_state_e state_q, state_d;
    logic        first_q, first_d;
    logic [9:0]  snap_q, snap_d;
    logic [9:0]  cap_q, cap_d;
    logic [4:0]  dig0_q, dig0_d;
    logic [4:0]  dig1_q, dig1_d;
    logic [4:0]  dig2_q, dig2_d;
    logic [4:0]  dig3_q, dig3_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic [4:0]  cur_digit;
    logic [7:0]  cur_seg;

`ifndef SEG7_HEX_EN
    logic [19:0] shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [19:0] shift_adj;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decade.
    always_comb begin
        shift_adj = shreg_q;
        for (int i = 0; i < 3; i++) begin
            if (shreg_q[8 + 4*i +: 4] >= 4'd5) begin
                shift_adj[8 + 4*i +: 4] = shreg_q[8 + 4*i +: 4] + 4'd3;
            end
        end
    end
`endif

    // Conversion FSM: IDLE watches for a new {debug,dind} pair, SHIFT runs the
    // eight dabble steps, LOAD publishes the digits. The captured pair, not the
    // live inputs, feeds LOAD so changes mid-conversion wait for the next IDLE.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        snap_d  = snap_q;
        cap_d   = cap_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        dig2_d  = dig2_q;
        dig3_d  = dig3_q;
`ifndef SEG7_HEX_EN
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (first_q || ({debug_i, dind_i} != snap_q)) begin
                    cap_d = {debug_i, dind_i};
`ifdef SEG7_HEX_EN
                    state_d = ST_LOAD;
`else
                    shreg_d  = {12'd0, dind_i};
                    bitcnt_d = 3'd7;
                    state_d  = ST_SHIFT;
`endif
                end
            end
`ifndef SEG7_HEX_EN
            ST_SHIFT: begin
                shreg_d = shift_adj << 1;
                if (bitcnt_q == 3'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    bitcnt_d = bitcnt_q - 3'd1;
                end
            end
`endif
            ST_LOAD: begin
`ifdef SEG7_HEX_EN
                dig0_d = {1'b0, cap_q[3:0]};
                dig1_d = {1'b0, cap_q[7:4]};
                dig2_d = DIGIT_BLANK;
`else
                dig0_d = {1'b0, shreg_q[11:8]};
                dig1_d = (cap_q[7:0] < 8'd10)  ? DIGIT_BLANK : {1'b0, shreg_q[15:12]};
                dig2_d = (cap_q[7:0] < 8'd100) ? DIGIT_BLANK : {1'b0, shreg_q[19:16]};
`endif
                dig3_d  = {3'b000, cap_q[9:8]};
                snap_d  = cap_q;
                first_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan: the prescaler sets slot length, the index walks the four digits.
    // Segments and anodes are registered together from the same index so the
    // pattern and the enabled digit always belong to each other.
    always_comb begin
        presc_d = presc_q + 16'd1;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = 16'd0;
            idx_d   = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = cur_seg;
    end

    // Select the digit currently being scanned.
    always_comb begin
        cur_digit = dig0_q;
        case (idx_q)
            2'd0: cur_digit = dig0_q;
            2'd1: cur_digit = dig1_q;
            2'd2: cur_digit = dig2_q;
            2'd3: cur_digit = dig3_q;
        endcase
    end

    seg7_decode u_decode (
        .digit_i (cur_digit),
        .seg_o   (cur_seg)
    );

    // All state registers; reset leaves the display dark and forces a fresh
    // conversion through the first flag.
    always_ff @(posedge clc_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            first_q <= 1'b1;
            snap_q  <= 10'd0;
            cap_q   <= 10'd0;
            dig0_q  <= 5'd0;
            dig1_q  <= DIGIT_BLANK;
            dig2_q  <= DIGIT_BLANK;
            dig3_q  <= 5'd0;
            presc_q <= 16'd0;
            idx_q   <= 2'd0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
`ifndef SEG7_HEX_EN
            shreg_q  <= 20'd0;
            bitcnt_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            snap_q  <= snap_d;
            cap_q   <= cap_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            dig3_q  <= dig3_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
`ifndef SEG7_HEX_EN
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
`endif
        end
    end

    assign seg_out  = seg_q;
    assign an_out   = an_q;
    assign busy_out = (state_q != ST_IDLE);

endmodule
